// File: rtl/adc_cfg_sequencer.sv
// Sequences a shadow table of ADC register values into the 3-wire serial engine,
// one write frame per register, with an optional readback-and-compare pass.
module adc_cfg_sequencer #(
    parameter int unsigned NUM_REGS       = 8,
    parameter bit          VERIFY         = 1'b1,
    parameter int unsigned GAP_CYCLES     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       tbl_we,
    input  logic [2:0] tbl_addr,
    input  logic [8:0] tbl_data,
    output logic       wr_req,
    output logic       wr_rw,
    output logic [2:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic       wr_done,
    input  logic [8:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       verify_err,
    output logic [2:0] err_addr,
    output logic       timeout_err
);
    localparam int unsigned DW    = 9;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW    = $clog2(GAP_CYCLES + 1);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_GAP,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            pass_q, pass_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [DW-1:0]   rd_cap_q, rd_cap_d;
    logic [DW-1:0]   tbl_q [DEPTH];
    logic [DW-1:0]   tbl_d [DEPTH];
    logic            wr_req_q, wr_req_d;
    logic            wr_rw_q, wr_rw_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            verify_err_q, verify_err_d;
    logic [AW-1:0]   err_addr_q, err_addr_d;
    logic            timeout_err_q, timeout_err_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pass_d        = pass_q;
        tmo_d         = tmo_q;
        gap_d         = gap_q;
        rd_cap_d      = rd_cap_q;
        tbl_d         = tbl_q;
        wr_req_d      = wr_req_q;
        wr_rw_d       = wr_rw_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        verify_err_d  = verify_err_q;
        err_addr_d    = err_addr_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            S_IDLE: begin
                // Table write lands before go so the first frame sees it
                if (tbl_we) begin
                    tbl_d[tbl_addr] = tbl_data;
                end
                if (go) begin
                    verify_err_d  = 1'b0;
                    timeout_err_d = 1'b0;
                    idx_d         = '0;
                    pass_d        = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wr_req_d  = 1'b1;
                wr_rw_d   = ~pass_q;
                wr_addr_d = idx_q;
                wr_data_d = pass_q ? '0 : tbl_q[idx_q];
                tmo_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (wr_done) begin
                    wr_req_d = 1'b0;
                    if (pass_q) begin
                        rd_cap_d = rd_data;
                    end
                    state_d = S_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    wr_req_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    state_d       = S_FINISH;
                end
            end
            S_CHECK: begin
                if (pass_q && (rd_cap_q != tbl_q[idx_q])) begin
                    verify_err_d = 1'b1;
                    if (!verify_err_q) begin
                        err_addr_d = idx_q;
                    end
                end
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end else if (!pass_q && VERIFY) begin
                        pass_d  = 1'b1;
                        idx_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            pass_q        <= 1'b0;
            tmo_q         <= '0;
            gap_q         <= '0;
            rd_cap_q      <= '0;
            tbl_q         <= '{default: '0};
            wr_req_q      <= 1'b0;
            wr_rw_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            verify_err_q  <= 1'b0;
            err_addr_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pass_q        <= pass_d;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
            rd_cap_q      <= rd_cap_d;
            tbl_q         <= tbl_d;
            wr_req_q      <= wr_req_d;
            wr_rw_q       <= wr_rw_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            verify_err_q  <= verify_err_d;
            err_addr_q    <= err_addr_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign wr_req      = wr_req_q;
    assign wr_rw       = wr_rw_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign verify_err  = verify_err_q;
    assign err_addr    = err_addr_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Bench for adc_cfg_sequencer: a verify instance and a write-only instance, driven
// by a serial-engine responder, with expected frames scored from a table model.
`timescale 1ns/1ps
module tb_adc_cfg_sequencer;
    localparam int unsigned GAP = 20;
    localparam int unsigned TMO = 1024;

    typedef struct packed {
        logic       rw;
        logic [2:0] addr;
        logic [8:0] data;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       go_s       [2];
    logic       tbl_we_s   [2];
    logic [2:0] tbl_addr;
    logic [8:0] tbl_data;
    logic       wr_req_s   [2];
    logic       wr_rw_s    [2];
    logic [2:0] wr_addr_s  [2];
    logic [8:0] wr_data_s  [2];
    logic       wr_done_s  [2];
    logic [8:0] rd_data;
    logic       busy_s     [2];
    logic       done_s     [2];
    logic       verify_err_s  [2];
    logic [2:0] err_addr_s    [2];
    logic       timeout_err_s [2];

    always #5 clk = ~clk;

    // Instance 0 verifies, instance 1 is write-only
    for (genvar g = 0; g < 2; g++) begin : g_dut
        adc_cfg_sequencer #(
            .NUM_REGS(8), .VERIFY(g == 0), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .go(go_s[g]), .tbl_we(tbl_we_s[g]),
            .tbl_addr(tbl_addr), .tbl_data(tbl_data),
            .wr_req(wr_req_s[g]), .wr_rw(wr_rw_s[g]), .wr_addr(wr_addr_s[g]),
            .wr_data(wr_data_s[g]), .wr_done(wr_done_s[g]), .rd_data(rd_data),
            .busy(busy_s[g]), .done(done_s[g]), .verify_err(verify_err_s[g]),
            .err_addr(err_addr_s[g]), .timeout_err(timeout_err_s[g])
        );
    end

    int         checks = 0;
    int         errors = 0;
    int         sel = 0;
    frame_t     exp_q [$];
    logic [8:0] tbl_m [2][8];
    logic [2:0] eaddr_m [2];
    logic [8:0] adc_m [8];
    bit         resp_en = 1'b1;
    bit         rand_delay = 1'b1;
    int         resp_delay = 10;
    logic [7:0] corrupt_mask = '0;
    logic [8:0] corrupt_xor = '0;
    bit         ghost_gap = 1'b0;
    int         ghost_cnt = 0;
    int         done_cnt = 0;
    int         frame_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scores every frame the active instance issues
    initial begin : monitor
        bit     prev_req;
        int     low;
        frame_t act;
        frame_t held;
        bit     stable;
        prev_req = 1'b0;
        low = 1000;
        stable = 1'b1;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                low = 1000;
            end else begin
                act = {wr_rw_s[sel], wr_addr_s[sel], wr_data_s[sel]};
                if (done_s[sel]) done_cnt++;
                if (wr_req_s[sel] && !prev_req) begin
                    frame_cnt++;
                    check("frame_gap", 32'(low >= int'(GAP)), 1);
                    check("frame_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("frame", 32'(act), 32'(exp_q.pop_front()));
                    held = act;
                    stable = 1'b1;
                end else if (wr_req_s[sel] && prev_req) begin
                    if (act != held) stable = 1'b0;
                end else if (!wr_req_s[sel] && prev_req) begin
                    check("frame_stable", 32'(stable), 1);
                    low = 0;
                end
                if (!wr_req_s[sel]) low++;
                prev_req = wr_req_s[sel];
            end
        end
    end

    // Responder: behaves as the serial engine with its own register file
    initial begin : responder
        bit in_frame;
        bit acked;
        int cnt;
        int cur_delay;
        int gap_wait;
        int ghost_served;
        in_frame = 1'b0;
        acked = 1'b0;
        cnt = 0;
        cur_delay = 0;
        gap_wait = -1;
        ghost_served = 0;
        wr_done_s[0] = 1'b0;
        wr_done_s[1] = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk);
            wr_done_s[0] = 1'b0;
            wr_done_s[1] = 1'b0;
            if (!rst_n) begin
                in_frame = 1'b0;
                gap_wait = -1;
            end else if (ghost_served != ghost_cnt) begin
                ghost_served++;
                wr_done_s[sel] = 1'b1;
                rd_data = 9'($urandom);
            end else if (wr_req_s[sel]) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    acked = 1'b0;
                    cnt = 0;
                    cur_delay = rand_delay ? int'($urandom_range(2, 40)) : resp_delay;
                end else begin
                    cnt++;
                end
                if (resp_en && !acked && cnt == cur_delay) begin
                    acked = 1'b1;
                    wr_done_s[sel] = 1'b1;
                    if (wr_rw_s[sel]) begin
                        adc_m[wr_addr_s[sel]] = wr_data_s[sel];
                        rd_data = 9'($urandom);
                    end else begin
                        rd_data = adc_m[wr_addr_s[sel]] ^
                                  (corrupt_mask[wr_addr_s[sel]] ? corrupt_xor : 9'h000);
                    end
                end
            end else begin
                if (in_frame) gap_wait = ghost_gap ? 5 : -1;
                in_frame = 1'b0;
                if (gap_wait == 0) begin
                    wr_done_s[sel] = 1'b1;
                    rd_data = 9'($urandom);
                end
                if (gap_wait >= 0) gap_wait--;
            end
        end
    end

    task automatic tbl_write(input logic [2:0] a, input logic [8:0] v);
        @(negedge clk);
        tbl_we_s[sel] = 1'b1;
        tbl_addr = a;
        tbl_data = v;
        tbl_m[sel][a] = v;
        @(negedge clk);
        tbl_we_s[sel] = 1'b0;
    endtask

    // One full sequence, expectations derived from the table model
    task automatic run_seq(input string name, input bit hold, input bit we_with_go);
        logic [2:0] wa;
        logic [8:0] wv;
        logic [8:0] rb;
        int         n_exp;
        bit         exp_verr;
        bit         seen;
        wa = 3'($urandom);
        wv = 9'($urandom);
        if (we_with_go) tbl_m[sel][wa] = wv;
        exp_verr = 1'b0;
        n_exp = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({1'b1, 3'(i), tbl_m[sel][i]});
            n_exp++;
        end
        if (sel == 0) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back({1'b0, 3'(i), 9'h000});
                n_exp++;
                rb = tbl_m[sel][i] ^ (corrupt_mask[i] ? corrupt_xor : 9'h000);
                if (rb != tbl_m[sel][i] && !exp_verr) begin
                    exp_verr = 1'b1;
                    eaddr_m[sel] = 3'(i);
                end
            end
        end
        frame_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        go_s[sel] = 1'b1;
        if (we_with_go) begin
            tbl_we_s[sel] = 1'b1;
            tbl_addr = wa;
            tbl_data = wv;
        end
        @(negedge clk);
        go_s[sel] = 1'b0;
        tbl_we_s[sel] = 1'b0;
        check({name, "_busy"}, 32'(busy_s[sel]), 1);
        check({name, "_req_early"}, 32'(wr_req_s[sel]), 0);
        @(negedge clk);
        check({name, "_req_latency"}, 32'(wr_req_s[sel]), 1);
        seen = 1'b0;
        for (int c = 0; c < 40000; c++) begin
            if (done_s[sel]) begin
                seen = 1'b1;
                break;
            end
            if (hold) begin
                go_s[sel] = 1'b1;
                tbl_we_s[sel] = 1'b1;
                tbl_addr = 3'($urandom);
                tbl_data = 9'($urandom);
            end
            @(negedge clk);
        end
        go_s[sel] = 1'b0;
        tbl_we_s[sel] = 1'b0;
        check({name, "_done_seen"}, 32'(seen), 1);
        check({name, "_busy_at_done"}, 32'(busy_s[sel]), 0);
        repeat (40) @(negedge clk);
        check({name, "_done_pulses"}, 32'(done_cnt), 1);
        check({name, "_frames"}, 32'(frame_cnt), 32'(n_exp));
        check({name, "_queue_left"}, 32'(exp_q.size()), 0);
        check({name, "_verify_err"}, 32'(verify_err_s[sel]), 32'(exp_verr));
        check({name, "_err_addr"}, 32'(err_addr_s[sel]), 32'(eaddr_m[sel]));
        check({name, "_timeout_err"}, 32'(timeout_err_s[sel]), 0);
        check({name, "_busy_after"}, 32'(busy_s[sel]), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        for (int g = 0; g < 2; g++) begin
            eaddr_m[g] = '0;
            for (int i = 0; i < 8; i++) tbl_m[g][i] = '0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cnt;
        for (int g = 0; g < 2; g++) begin
            go_s[g] = 1'b0;
            tbl_we_s[g] = 1'b0;
        end
        tbl_addr = '0;
        tbl_data = '0;
        for (int i = 0; i < 8; i++) adc_m[i] = '0;
        #2;
        do_reset();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_wr_req", 32'(wr_req_s[g]), 0);
            check("rst_outputs", 32'({wr_rw_s[g], wr_addr_s[g], wr_data_s[g]}), 0);
            check("rst_status", 32'({busy_s[g], done_s[g], verify_err_s[g],
                                     err_addr_s[g], timeout_err_s[g]}), 0);
        end

        // Stray wr_done while idle
        sel = 0;
        done_cnt = 0;
        frame_cnt = 0;
        ghost_cnt++;
        repeat (4) @(negedge clk);
        check("idle_ghost_state", 32'({busy_s[0], wr_req_s[0], verify_err_s[0], timeout_err_s[0]}), 0);
        check("idle_ghost_done", 32'(done_cnt), 0);

        // Write-only instance, fixed 320-cycle acknowledge
        sel = 1;
        rand_delay = 1'b0;
        resp_delay = 320;
        for (int i = 0; i < 8; i++) tbl_write(3'(i), 9'h0C8 + 9'(i));
        run_seq("wr_only", 1'b0, 1'b0);

        // Verify instance, register 5 reads back as zero
        sel = 0;
        rand_delay = 1'b1;
        for (int i = 0; i < 8; i++) tbl_write(3'(i), 9'h0C8 + 9'(i));
        corrupt_mask = 8'h20;
        corrupt_xor = 9'h0CD;
        run_seq("verify_addr5", 1'b0, 1'b0);

        // Randomized tables and readback faults with stray pulses in GAP
        ghost_gap = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = (k == 3) ? 1 : 0;
            for (int i = 0; i < 8; i++) tbl_write(3'(i), 9'($urandom));
            corrupt_mask = (k == 1) ? 8'h00 : 8'($urandom);
            corrupt_xor = 9'($urandom_range(1, 511));
            run_seq($sformatf("rand%0d", k), 1'b0, (k == 0));
        end
        ghost_gap = 1'b0;
        corrupt_mask = '0;

        // go and tbl_we held through a sequence, then a clean rerun
        sel = 0;
        run_seq("hold_go", 1'b1, 1'b0);
        run_seq("after_hold", 1'b0, 1'b0);

        // Acknowledge on the last cycle before timeout
        sel = 1;
        rand_delay = 1'b0;
        resp_delay = int'(TMO) - 1;
        run_seq("ack_at_limit", 1'b0, 1'b0);
        rand_delay = 1'b1;

        // No acknowledge at all
        sel = 0;
        resp_en = 1'b0;
        frame_cnt = 0;
        done_cnt = 0;
        exp_q.push_back({1'b1, 3'd0, tbl_m[0][0]});
        @(negedge clk);
        go_s[0] = 1'b1;
        @(negedge clk);
        go_s[0] = 1'b0;
        @(negedge clk);
        check("tmo_req_rise", 32'(wr_req_s[0]), 1);
        cnt = 0;
        while (!timeout_err_s[0] && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("tmo_latency", 32'(cnt), 32'(TMO));
        check("tmo_req_low", 32'(wr_req_s[0]), 0);
        check("tmo_done", 32'(done_s[0]), 1);
        check("tmo_busy", 32'(busy_s[0]), 0);
        repeat (60) @(negedge clk);
        check("tmo_frames", 32'(frame_cnt), 1);
        check("tmo_done_pulses", 32'(done_cnt), 1);
        check("tmo_sticky", 32'({timeout_err_s[0], verify_err_s[0]}), 32'(2'b10));

        // Reset while a frame is outstanding
        exp_q.push_back({1'b1, 3'd0, tbl_m[0][0]});
        @(negedge clk);
        go_s[0] = 1'b1;
        @(negedge clk);
        go_s[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_pre_req", 32'(wr_req_s[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_req", 32'(wr_req_s[0]), 0);
        check("rst_async_status", 32'({busy_s[0], timeout_err_s[0], verify_err_s[0]}), 0);
        do_reset();
        resp_en = 1'b1;
        run_seq("post_reset_zero_tbl", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
